divider_32bit_seq: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Inverse-operation partner of the combinational multiplier; sits beside it in the EX stage.
- The pipeline stalls on busy and captures the result on valid.
- Operands are latched on start; one quotient bit is produced per cycle.

---
 rtl/divider_32bit_seq_if.sv | 23 ++
 rtl/divider_32bit_seq.sv | 146 ++++++++++++++
 tb/tb_divider_32bit_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_32bit_seq_if.sv
// Handshake and operand bundle between the EX-stage pipeline (master) and the divider (slave).
interface divider_32bit_seq_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        div_opcode;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic              start;
  logic              flush;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] result_divide;

  modport master (
    output div_opcode, operand1, operand2, start, flush,
    input  busy, valid, result_divide
  );

  modport slave (
    input  div_opcode, operand1, operand2, start, flush,
    output busy, valid, result_divide
  );
endinterface

// File: rtl/divider_32bit_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module divider_32bit_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  divider_32bit_seq_if.slave  div_if
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              signed_op;
  logic              ovf;
  logic [DATA_W-1:0] abs1, abs2;
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    valid_d   = 1'b0;
    result_d  = result_q;

    signed_op = ~div_if.div_opcode[0];
    abs1 = (signed_op && div_if.operand1[DATA_W-1]) ? -div_if.operand1 : div_if.operand1;
    abs2 = (signed_op && div_if.operand2[DATA_W-1]) ? -div_if.operand2 : div_if.operand2;
    ovf  = signed_op && (div_if.operand1 == {1'b1, {(DATA_W-1){1'b0}}})
                     && (div_if.operand2 == '1);

    shifted = {rem_q, dvd_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;

    case (state_q)
      S_IDLE: begin
        // valid_q marks the result cycle, which still counts as DONE for start acceptance
        if (div_if.start && !div_if.flush && !valid_q) begin
          opcode_d  = div_if.div_opcode;
          cnt_d     = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          state_d   = S_DONE;
          if (div_if.operand2 == '0) begin
            dvd_d = '1;
            rem_d = div_if.operand1;
          end else if (ovf) begin
            dvd_d = {1'b1, {(DATA_W-1){1'b0}}};
            rem_d = '0;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs1 < abs2) begin
            dvd_d = '0;
            rem_d = div_if.operand1;
          end
`endif
          else begin
            state_d   = S_CALC;
            dvd_d     = abs1;
            dvs_d     = abs2;
            rem_d     = '0;
            neg_quo_d = signed_op & (div_if.operand1[DATA_W-1] ^ div_if.operand2[DATA_W-1]);
            neg_rem_d = signed_op & div_if.operand1[DATA_W-1];
          end
        end
      end
      S_CALC: begin
        if (div_if.flush) begin
          state_d = S_IDLE;
        end else begin
          // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shifted[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!div_if.flush) begin
          valid_d  = 1'b1;
          result_d = opcode_q[1] ? rem_fix : quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign div_if.busy          = busy_q;
  assign div_if.valid         = valid_q;
  assign div_if.result_divide = result_q;
endmodule

// File: tb/tb_divider_32bit_seq.sv
// Self-checking bench for divider_32bit_seq: directed table, control corner cases, random ops.
module tb_divider_32bit_seq;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int EARLY_LAT = EARLY ? 1 : 33;

  logic clk;
  logic rst_n;
  int   cyc;
  int   t0;
  int   tests;
  int   fails;

  divider_32bit_seq_if #(.DATA_W(32)) dif ();

  divider_32bit_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // RISC-V M semantics in plain 64-bit arithmetic; INT_MIN/-1 wraps naturally when truncated.
  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    if (op[0]) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (sb == 0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    longint sa, sb;
    if (op[0]) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (EARLY && sa < sb) return 1;
    return 33;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.div_opcode = op;
    dif.operand1   = a;
    dif.operand2   = b;
    dif.start      = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    dif.start = 1'b0;
  endtask

  // Returns at #1 after the edge where valid rose; lat = -1 on timeout.
  task automatic wait_valid(input int max_cyc, output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      #1;
      if (dif.valid) begin
        lat = cyc - t0;
        break;
      end
      if (!dif.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic no_valid(input int n, output bit ok);
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (dif.valid) ok = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit busy_ok;
    bit busy0;
    launch(op, a, b);
    busy0 = dif.busy;
    wait_valid(60, lat, busy_ok);
    check({name, " res"}, dif.result_divide, exp_res);
    check({name, " lat"}, 32'(lat), 32'(exp_lat));
    check({name, " busy"}, {31'b0, busy0 & busy_ok}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit ok;
    bit busy_ok;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] last_res;

    tests = 0;
    fails = 0;
    cyc   = 0;
    t0    = 0;
    rst_n = 1'b0;
    dif.div_opcode = 2'b00;
    dif.operand1   = '0;
    dif.operand2   = '0;
    dif.start      = 1'b0;
    dif.flush      = 1'b0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, 33};
    vecs[1]  = '{2'b10, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 33};
    vecs[2]  = '{2'b11, 32'hFFFF_FFEC, 32'd3,        32'h0000_0002, 33};
    vecs[3]  = '{2'b01, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 1};
    vecs[4]  = '{2'b10, 32'h1234_5678, 32'd0,        32'h1234_5678, 1};
    vecs[5]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[7]  = '{2'b01, 32'd5,         32'd7,        32'h0000_0000, EARLY_LAT};
    vecs[8]  = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[10] = '{2'b11, 32'd100,       32'd7,        32'h0000_0002, 33};
    vecs[11] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};

    #1;
    check("reset busy",   {31'b0, dif.busy},  32'h0);
    check("reset valid",  {31'b0, dif.valid}, 32'h0);
    check("reset result", dif.result_divide,  32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // start during CALC is ignored, then start during the valid cycle is ignored
    launch(2'b01, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    dif.div_opcode = 2'b01;
    dif.operand1   = 32'd9;
    dif.operand2   = 32'd0;
    dif.start      = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_valid(60, lat, busy_ok);
    check("calc start res", dif.result_divide, 32'd14);
    check("calc start lat", 32'(lat), 32'd33);
    check("calc start busy", {31'b0, busy_ok}, 32'h1);
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check("valid start busy", {31'b0, dif.busy}, 32'h0);
    no_valid(40, ok);
    check("no queued op", {31'b0, ok}, 32'h1);
    last_res = 32'd14;

    // flush at iteration 10
    launch(2'b00, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    check("flush busy",   {31'b0, dif.busy},  32'h0);
    check("flush valid",  {31'b0, dif.valid}, 32'h0);
    check("flush result", dif.result_divide,  last_res);
    no_valid(40, ok);
    check("flush no valid", {31'b0, ok}, 32'h1);

    // flush in DONE of a special-case op
    launch(2'b01, 32'd9, 32'd0);
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    check("done flush busy", {31'b0, dif.busy}, 32'h0);
    no_valid(5, ok);
    check("done flush no valid", {31'b0, ok}, 32'h1);
    check("done flush result", dif.result_divide, last_res);

    // flush beats start in IDLE
    @(negedge clk);
    dif.div_opcode = 2'b01;
    dif.operand1   = 32'd5;
    dif.operand2   = 32'd0;
    dif.start      = 1'b1;
    dif.flush      = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.flush = 1'b0;
    check("flush prio busy", {31'b0, dif.busy}, 32'h0);
    no_valid(5, ok);
    check("flush prio no valid", {31'b0, ok}, 32'h1);

    // asynchronous reset mid-CALC
    launch(2'b01, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy",   {31'b0, dif.busy},  32'h0);
    check("arst valid",  {31'b0, dif.valid}, 32'h0);
    check("arst result", dif.result_divide,  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid(40, ok);
    check("arst no valid", {31'b0, ok}, 32'h1);
    run_op("after reset", 2'b01, 32'd1000, 32'd3, 32'd333, 33);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = $urandom >> $urandom_range(0, 31);
        5: begin a = $urandom_range(0, 100); b = $urandom_range(1, 200); end
        default: b = $urandom;
      endcase
      if (b == 32'h0 && $urandom_range(0, 1) == 0) b = 32'd1;
      run_op($sformatf("rnd%0d op%0d %h/%h", i, op, a, b), op, a, b,
             model_res(op, a, b), model_lat(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
